// File: rtl/pq_pkg.sv
// Shared types and constants for the register-array priority queue.
// An empty slot holds KV_EMPTY so it sorts after every legal key.
package pq_pkg;

    localparam int KEY_BITS = 8;
    localparam int VAL_BITS = 8;

    typedef struct packed {
        logic [KEY_BITS-1:0] key;
        logic [VAL_BITS-1:0] val;
    } kv_t;

    localparam logic [KEY_BITS-1:0] KEYINF   = '1;
    localparam logic [VAL_BITS-1:0] VAL0     = '0;
    localparam kv_t                 KV_EMPTY = '{key: KEYINF, val: VAL0};

endpackage

// File: rtl/ra_pq_reg.sv
// One priority-queue slot: a kv_t register that resets to the empty marker.
module ra_pq_reg
    import pq_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  kv_t  d,
    output kv_t  q
);

    // NOTE: every slot is reset, not just the count: the insert compare relies on
    // unused slots holding KEYINF, so stale contents would corrupt the ordering.
    // NOTE: non-blocking assignment keeps all slots updating from the same
    // pre-edge values, which the neighbour-to-neighbour shift depends on.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= KV_EMPTY;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/ra_pq_array.sv
// Systolic-shift priority queue: DEPTH sorted slots, minimum key always in slot 0.
// Delete shifts the array down by one; insert then splices ki into the (possibly shifted) view.
module ra_pq_array
    import pq_pkg::*;
#(
    parameter  int DEPTH = 8,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq,
    input  kv_t           ki,
    input  logic          deq,
    output kv_t           ko,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count
);

    kv_t              slot_q [DEPTH];
    kv_t              shf    [DEPTH];
    logic [DEPTH-1:0] lt;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             empty_q;
    logic             full_q;
    logic             enq_eff;
    logic             deq_eff;

    // A deq frees a slot this cycle, so enq on full is accepted alongside it.
    assign enq_eff = enq & (~full_q | deq);
    assign deq_eff = deq & ~empty_q;

    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            shf[i] = deq_eff ? slot_q[i+1] : slot_q[i];
        end
        shf[DEPTH-1] = deq_eff ? KV_EMPTY : slot_q[DEPTH-1];
    end

    // Strict less-than puts a new item behind existing equal keys.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            lt[i] = (ki.key < shf[i].key);
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_slot
        kv_t slot_nxt;

        if (i == 0) begin : g_head
            assign slot_nxt = (enq_eff && lt[0]) ? ki : shf[0];
        end else begin : g_body
            assign slot_nxt = (enq_eff && lt[i-1]) ? shf[i-1] :
                              (enq_eff && lt[i])   ? ki        : shf[i];
        end

        ra_pq_reg u_slot (
            .clk (clk),
            .rst (rst),
            .d   (slot_nxt),
            .q   (slot_q[i])
        );
    end

    // NOTE: count_d takes its default first so no path through this block
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        count_d = count_q;
        if (enq_eff && !deq_eff) begin
            count_d = count_q + 1'b1;
        end else if (!enq_eff && deq_eff) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            empty_q <= (count_d == '0);
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    assign ko    = slot_q[0];
    assign count = count_q;
    assign empty = empty_q;
    assign full  = full_q;

    a_no_keyinf_enq: assert property (@(posedge clk) disable iff (rst) enq |-> (ki.key != KEYINF));

endmodule

// File: tb/tb_ra_pq_array.sv
// Directed and model-checked stimulus for ra_pq_array (DEPTH = 8).
module tb_ra_pq_array;
    import pq_pkg::*;

    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          rst;
    logic          enq;
    logic          deq;
    kv_t           ki;
    kv_t           ko;
    logic          empty;
    logic          full;
    logic [CW-1:0] count;

    int  n_cmp = 0;
    int  n_err = 0;
    kv_t model[$];
    kv_t drain_exp[8];

    ra_pq_array #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst   (rst),
        .enq   (enq),
        .ki    (ki),
        .deq   (deq),
        .ko    (ko),
        .empty (empty),
        .full  (full),
        .count (count)
    );

    always #5 clk = ~clk;

    function automatic kv_t kv(input int k, input int v);
        kv_t r;
        r.key = KEY_BITS'(k);
        r.val = VAL_BITS'(v);
        return r;
    endfunction

    task automatic check(input string tag, input kv_t exp_ko, input int exp_cnt);
        logic [31:0] obs;
        logic [31:0] exp;
        obs = 32'({ko, count, empty, full});
        exp = 32'({exp_ko, CW'(exp_cnt), (exp_cnt == 0), (exp_cnt == DEPTH)});
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed ko=%h count=%0d empty=%0b full=%0b, expected ko=%h count=%0d empty=%0b full=%0b",
                   tag, ko, count, empty, full, exp_ko, exp_cnt, (exp_cnt == 0), (exp_cnt == DEPTH));
        end
    endtask

    task automatic step(input logic e, input kv_t k, input logic d);
        enq = e;
        ki  = k;
        deq = d;
        @(posedge clk);
        #1;
        enq = 1'b0;
        deq = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        enq = 1'b0;
        deq = 1'b0;
        ki  = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: reset then idle
        check("reset", KV_EMPTY, 0);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, '0, 1'b0);
            check("idle", KV_EMPTY, 0);
        end

        // 2: ties are FIFO
        step(1'b1, kv(5, 8'h51), 1'b0);  check("enq5",  kv(5, 8'h51), 1);
        step(1'b1, kv(3, 8'h0A), 1'b0);  check("enq3a", kv(3, 8'h0A), 2);
        step(1'b1, kv(9, 8'h91), 1'b0);  check("enq9",  kv(3, 8'h0A), 3);
        step(1'b1, kv(3, 8'h0B), 1'b0);  check("enq3b", kv(3, 8'h0A), 4);
        step(1'b0, '0, 1'b1);            check("deq1",  kv(3, 8'h0B), 3);
        step(1'b0, '0, 1'b1);            check("deq2",  kv(5, 8'h51), 2);
        step(1'b0, '0, 1'b1);            check("deq3",  kv(9, 8'h91), 1);
        step(1'b0, '0, 1'b1);            check("deq4",  KV_EMPTY, 0);

        // 3: fill with 8..1, then enq on full is dropped
        for (int k = 8; k >= 1; k--) begin
            step(1'b1, kv(k, 8'h80 | k), 1'b0);
            check("fill", kv(k, 8'h80 | k), 9 - k);
        end
        step(1'b1, kv(0, 8'h00), 1'b0);  check("drop_full", kv(1, 8'h81), 8);

        // 4: replace on full, then drain to confirm order (new 4 after old 4)
        step(1'b1, kv(4, 8'h44), 1'b1);  check("replace", kv(2, 8'h82), 8);
        drain_exp = '{kv(3, 8'h83), kv(4, 8'h84), kv(4, 8'h44), kv(5, 8'h85),
                      kv(6, 8'h86), kv(7, 8'h87), kv(8, 8'h88), KV_EMPTY};
        for (int i = 0; i < 8; i++) begin
            step(1'b0, '0, 1'b1);
            check("drain", drain_exp[i], 7 - i);
        end

        // 5: deq on empty ignored; enq+deq on empty acts as insert
        step(1'b0, '0, 1'b1);            check("deq_empty",  KV_EMPTY, 0);
        step(1'b1, kv(7, 8'h77), 1'b1);  check("enqdeq_empty", kv(7, 8'h77), 1);
        step(1'b0, '0, 1'b1);            check("deq_last",   KV_EMPTY, 0);

        // 6: reset wins over enq and discards contents
        step(1'b1, kv(2, 8'h22), 1'b0);
        step(1'b1, kv(1, 8'h11), 1'b0);
        step(1'b1, kv(3, 8'h33), 1'b0);  check("pre_rst", kv(1, 8'h11), 3);
        rst = 1'b1;
        enq = 1'b1;
        ki  = kv(0, 8'h00);
        @(posedge clk);
        #1;
        rst = 1'b0;
        enq = 1'b0;
        check("rst_enq", KV_EMPTY, 0);
        step(1'b0, '0, 1'b0);            check("post_rst", KV_EMPTY, 0);
        step(1'b1, kv(6, 8'h66), 1'b0);  check("post_rst_enq", kv(6, 8'h66), 1);
        step(1'b0, '0, 1'b1);            check("post_rst_deq", KV_EMPTY, 0);

        // Random enq/deq against a sorted-list model
        for (int c = 0; c < 400; c++) begin
            logic re;
            logic rd;
            kv_t  rk;
            bit   ee;
            bit   de;
            int   pos;
            re  = ($urandom_range(0, 99) < ((c % 100) < 50 ? 75 : 25));
            rd  = ($urandom_range(0, 99) < ((c % 100) < 50 ? 25 : 75));
            rk  = kv($urandom_range(0, 254), $urandom_range(0, 255));
            ee  = re && ((model.size() < DEPTH) || rd);
            de  = rd && (model.size() > 0);
            step(re, rk, rd);
            if (de) void'(model.pop_front());
            if (ee) begin
                pos = model.size();
                for (int j = 0; j < model.size(); j++) begin
                    if (rk.key < model[j].key) begin
                        pos = j;
                        break;
                    end
                end
                model.insert(pos, rk);
            end
            check("random", (model.size() > 0) ? model[0] : KV_EMPTY, model.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
